// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and load/store (MEM) stages
//
// Purpose:
//   Shares one single-ported unified memory between instruction fetch and
//   data access. At most one transaction is outstanding at a time. The
//   response is routed back to the stage that issued the request, and
//   per-stage stalls are produced for pipeline control. Data accesses win
//   ties. A starvation counter forces a fetch grant after STARVE_MAX
//   consecutive data grants that happened while fetch was waiting.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   if_req_i, if_addr_i           fetch request (held until if_rvalid_o)
//   if_gnt_o, if_rvalid_o,
//   if_rdata_o                    fetch grant and response
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i, dm_be_i           data request (held until dm_rvalid_o)
//   dm_gnt_o, dm_rvalid_o,
//   dm_rdata_o                    data grant and response/store ack
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_be_o                      request strobe and muxed request fields
//   mem_rvalid_i, mem_rdata_i     memory response, one per mem_req_o
//   stall_if_o, stall_mem_o       pipeline hold requests

module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                stall_if_o,
  output logic                stall_mem_o
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic grant_ok;
  logic elig_if, elig_dm;
  logic gnt_if, gnt_dm;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A new request can issue from IDLE, or in the completion cycle of the
  // current transaction so back-to-back accesses lose no cycle. The owner of
  // the completing transaction is excluded: its req is still the old one.
  always_comb begin
    grant_ok = rst_ni && ((state_q == IDLE) || mem_rvalid_i);
    elig_if  = if_req_i && (state_q != BUSY_IF);
    elig_dm  = dm_req_i && (state_q != BUSY_DM);
    gnt_if   = 1'b0;
    gnt_dm   = 1'b0;
    if (grant_ok) begin
      if (elig_if && elig_dm) begin
        if (starve_q == STARVE_LIM) begin
          gnt_if = 1'b1;
        end else begin
          gnt_dm = 1'b1;
        end
      end else if (elig_if) begin
        gnt_if = 1'b1;
      end else if (elig_dm) begin
        gnt_dm = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // A response arriving in IDLE (late reply to an aborted transaction) leaves
  // the state untouched.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (gnt_if) begin
      state_d  = BUSY_IF;
      starve_d = '0;
    end else if (gnt_dm) begin
      state_d = BUSY_DM;
      if (if_req_i) begin
        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end else if ((state_q != IDLE) && mem_rvalid_i) begin
      state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Everything is gated by rst_ni so the outputs read 0 the moment reset is
  // asserted, not only after the next clock edge.
  always_comb begin
    if_gnt_o    = gnt_if;
    dm_gnt_o    = gnt_dm;
    mem_req_o   = gnt_if | gnt_dm;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;

    if (gnt_if) begin
      mem_addr_o = if_addr_i;
      mem_be_o   = '1;
    end else if (gnt_dm) begin
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_be_o    = dm_be_i;
    end

    if_rvalid_o = rst_ni && mem_rvalid_i && (state_q == BUSY_IF);
    dm_rvalid_o = rst_ni && mem_rvalid_i && (state_q == BUSY_DM);
    if_rdata_o  = rst_ni ? mem_rdata_i : '0;
    dm_rdata_o  = rst_ni ? mem_rdata_i : '0;

    stall_if_o  = rst_ni && if_req_i && !if_rvalid_o;
    stall_mem_o = rst_ni && dm_req_i && !dm_rvalid_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .STARVE_MAX (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_be_i     (dm_be_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well clear of either edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_ni       = 1'b0;
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0100;
    dm_req_i     = 1'b1;
    dm_we_i      = 1'b1;
    dm_addr_i    = 32'h0000_2000;
    dm_wdata_i   = 32'h1234_5678;
    dm_be_i      = 4'hf;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hAAAA_5555;

    // Reset: all outputs 0 even with active inputs
    settle();
    chk("rst_mem_req",   mem_req_o,   0);
    chk("rst_if_gnt",    if_gnt_o,    0);
    chk("rst_dm_gnt",    dm_gnt_o,    0);
    chk("rst_stall_if",  stall_if_o,  0);
    chk("rst_stall_mem", stall_mem_o, 0);
    chk("rst_if_rvalid", if_rvalid_o, 0);
    chk("rst_dm_rvalid", dm_rvalid_o, 0);
    chk("rst_mem_addr",  mem_addr_o,  0);
    chk("rst_if_rdata",  if_rdata_o,  0);
    tick();
    tick();
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    rst_ni = 1'b1;
    tick();

    // Single fetch
    if_req_i = 1; if_addr_i = 32'h100;
    settle();
    chk("f1_if_gnt",   if_gnt_o,   1);
    chk("f1_mem_req",  mem_req_o,  1);
    chk("f1_mem_addr", mem_addr_o, 32'h100);
    chk("f1_mem_we",   mem_we_o,   0);
    chk("f1_mem_be",   mem_be_o,   4'hf);
    chk("f1_stall_if", stall_if_o, 1);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    settle();
    chk("f1_if_rvalid", if_rvalid_o, 1);
    chk("f1_if_rdata",  if_rdata_o,  32'h0050_0093);
    chk("f1_stall_if0", stall_if_o,  0);
    chk("f1_no_regnt",  mem_req_o,   0);
    tick();
    if_req_i = 0; mem_rvalid_i = 0;
    settle();
    chk("f1_idle_req", mem_req_o, 0);
    tick();

    // Simultaneous requests: DM first, IF back-to-back in DM completion
    if_req_i = 1; if_addr_i = 32'h104;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h2000; dm_wdata_i = 32'h0; dm_be_i = 4'hf;
    settle();
    chk("sim_dm_gnt",    dm_gnt_o,    1);
    chk("sim_if_gnt0",   if_gnt_o,    0);
    chk("sim_mem_addr",  mem_addr_o,  32'h2000);
    chk("sim_stall_if",  stall_if_o,  1);
    chk("sim_stall_mem", stall_mem_o, 1);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h1122_3344;
    settle();
    chk("sim_dm_rvalid",  dm_rvalid_o, 1);
    chk("sim_dm_rdata",   dm_rdata_o,  32'h1122_3344);
    chk("sim_if_rvalid0", if_rvalid_o, 0);
    chk("sim_if_gnt_b2b", if_gnt_o,    1);
    chk("sim_dm_gnt0",    dm_gnt_o,    0);
    chk("sim_addr_b2b",   mem_addr_o,  32'h104);
    chk("sim_stall_mem0", stall_mem_o, 0);
    tick();
    dm_req_i = 0; mem_rdata_i = 32'h0000_0013;
    settle();
    chk("sim_if_rvalid", if_rvalid_o, 1);
    chk("sim_if_rdata",  if_rdata_o,  32'h0000_0013);
    tick();
    if_req_i = 0; mem_rvalid_i = 0;
    tick();

    // Store routing
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2004; dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'b0011;
    settle();
    chk("st_dm_gnt",    dm_gnt_o,    1);
    chk("st_mem_we",    mem_we_o,    1);
    chk("st_mem_be",    mem_be_o,    4'b0011);
    chk("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("st_mem_addr",  mem_addr_o,  32'h2004);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    settle();
    chk("st_dm_rvalid", dm_rvalid_o, 1);
    chk("st_if_rvalid", if_rvalid_o, 0);
    tick();
    dm_req_i = 0; dm_we_i = 0; dm_be_i = 4'hf; mem_rvalid_i = 0;
    tick();

    // Starvation: three DM grants with fetch waiting, then fetch is forced
    for (int k = 1; k <= 3; k++) begin
      if_req_i = 1; if_addr_i = 32'h200;
      dm_req_i = 1; dm_addr_i = 32'h3000 + 32'(4 * k);
      mem_rvalid_i = 0;
      settle();
      chk($sformatf("sv_dm_gnt_%0d", k), dm_gnt_o, 1);
      chk($sformatf("sv_if_gnt_%0d", k), if_gnt_o, 0);
      tick();
      if_req_i = 0; mem_rvalid_i = 1;
      settle();
      chk($sformatf("sv_dm_rvalid_%0d", k), dm_rvalid_o, 1);
      chk($sformatf("sv_idle_%0d", k), mem_req_o, 0);
      tick();
    end
    if_req_i = 1; if_addr_i = 32'h200; dm_req_i = 1; dm_addr_i = 32'h3010; mem_rvalid_i = 0;
    settle();
    chk("sv_if_forced",  if_gnt_o,   1);
    chk("sv_dm_gnt0",    dm_gnt_o,   0);
    chk("sv_forced_adr", mem_addr_o, 32'h200);
    tick();
    dm_req_i = 0; mem_rvalid_i = 1;
    settle();
    chk("sv_if_rvalid", if_rvalid_o, 1);
    chk("sv_no_gnt",    mem_req_o,   0);
    tick();
    // Counter cleared by the forced fetch: DM wins a tie again
    dm_req_i = 1; dm_addr_i = 32'h3020; if_addr_i = 32'h204; mem_rvalid_i = 0;
    settle();
    chk("sv_clr_dm_gnt", dm_gnt_o, 1);
    chk("sv_clr_if_gnt", if_gnt_o, 0);
    tick();
    mem_rvalid_i = 1;
    settle();
    chk("sv_clr_b2b_if", if_gnt_o, 1);
    tick();
    dm_req_i = 0;
    settle();
    chk("sv_clr_if_rv", if_rvalid_o, 1);
    tick();
    if_req_i = 0; mem_rvalid_i = 0;
    tick();

    // Reset mid-transaction
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h4000;
    settle();
    chk("rm_dm_gnt", dm_gnt_o, 1);
    tick();
    rst_ni = 0;
    settle();
    chk("rm_mem_req",   mem_req_o,   0);
    chk("rm_dm_gnt0",   dm_gnt_o,    0);
    chk("rm_stall_mem", stall_mem_o, 0);
    chk("rm_mem_addr",  mem_addr_o,  0);
    tick();
    dm_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    rst_ni = 1;
    settle();
    chk("rm_late_dm_rv", dm_rvalid_o, 0);
    chk("rm_late_if_rv", if_rvalid_o, 0);
    tick();
    mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h300;
    settle();
    chk("rm_idle_if_gnt", if_gnt_o,   1);
    chk("rm_idle_addr",   mem_addr_o, 32'h300);
    tick();
    mem_rvalid_i = 1;
    settle();
    chk("rm_if_rvalid", if_rvalid_o, 1);
    tick();
    if_req_i = 0; mem_rvalid_i = 0;
    tick();

    // Same-owner reissue
    if_req_i = 1; if_addr_i = 32'h104;
    settle();
    chk("ro_if_gnt", if_gnt_o, 1);
    tick();
    mem_rvalid_i = 1;
    settle();
    chk("ro_if_rvalid", if_rvalid_o, 1);
    chk("ro_no_gnt",    if_gnt_o,    0);
    chk("ro_no_req",    mem_req_o,   0);
    tick();
    if_addr_i = 32'h108; mem_rvalid_i = 0;
    settle();
    chk("ro_regnt",    if_gnt_o,   1);
    chk("ro_addr",     mem_addr_o, 32'h108);
    chk("ro_stall_if", stall_if_o, 1);
    tick();
    mem_rvalid_i = 1;
    settle();
    chk("ro_if_rvalid2", if_rvalid_o, 1);
    tick();
    if_req_i = 0; mem_rvalid_i = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
